// File: rtl/tff_toggle_sequencer_if.sv
// Command handshake between a control source and the tff toggle sequencer.
interface tff_toggle_sequencer_if #(
  parameter int NCH = 3,
  parameter int CW  = 8,
  parameter int GW  = 8
);
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  logic           cmd_valid;
  logic           cmd_ready;
  logic [CHW-1:0] cmd_ch;
  logic [CW-1:0]  cmd_count;
  logic [GW-1:0]  cmd_gap;

  modport master (
    output cmd_valid,
    output cmd_ch,
    output cmd_count,
    output cmd_gap,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_ch,
    input  cmd_count,
    input  cmd_gap,
    output cmd_ready
  );
endinterface

// File: rtl/tff_toggle_sequencer.sv
// Issues a programmed number of single-cycle toggle pulses to one channel of
// a T flip-flop bank per accepted command, with a programmable idle gap.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// PULSE | one-cycle toggle enable on the latched channel
// GAP   | idle cycles between pulses, counted down from the latched gap
// DONE  | one-cycle completion strobe (err if the channel was out of range)
module tff_toggle_sequencer #(
  parameter int NCH = 3,
  parameter int CW  = 8,
  parameter int GW  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  tff_toggle_sequencer_if.slave cmd,
  input  logic                  abort,
  output logic [NCH-1:0]        t_out,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [CW-1:0]         pulses_left
);
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {IDLE, PULSE, GAP, DONE} state_t;

  state_t         state_q, state_d;
  logic [CHW-1:0] ch_q, ch_d;
  logic [GW-1:0]  gap_q, gap_d;
  logic [GW-1:0]  gap_cnt_q, gap_cnt_d;
  logic [CW-1:0]  left_q, left_d;
  logic [NCH-1:0] t_out_q, t_out_d;
  logic           done_q, done_d;
  logic           err_q, err_d;
  logic           cmd_ch_ok;

  function automatic logic [NCH-1:0] ch_mask(input logic [CHW-1:0] ch);
    return NCH'(1) << ch;
  endfunction

  assign cmd_ch_ok = (32'(cmd.cmd_ch) < NCH);

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    gap_d     = gap_q;
    gap_cnt_d = gap_cnt_q;
    left_d    = left_q;
    t_out_d   = '0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd.cmd_valid) begin
          ch_d   = cmd.cmd_ch;
          gap_d  = cmd.cmd_gap;
          left_d = cmd.cmd_count;
          if (cmd.cmd_count == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else if (!cmd_ch_ok) begin
            state_d = DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d = PULSE;
            t_out_d = ch_mask(cmd.cmd_ch);
          end
        end
      end
      PULSE: begin
        // The pulse driven this cycle is always counted, even on abort.
        left_d = left_q - 1'b1;
        if (abort || left_q == CW'(1)) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else if (gap_q == '0) begin
          state_d = PULSE;
          t_out_d = ch_mask(ch_q);
        end else begin
          state_d   = GAP;
          gap_cnt_d = gap_q;
        end
      end
      GAP: begin
        if (abort) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else if (gap_cnt_q == GW'(1)) begin
          state_d = PULSE;
          t_out_d = ch_mask(ch_q);
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      ch_q      <= '0;
      gap_q     <= '0;
      gap_cnt_q <= '0;
      left_q    <= '0;
      t_out_q   <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      gap_q     <= gap_d;
      gap_cnt_q <= gap_cnt_d;
      left_q    <= left_d;
      t_out_q   <= t_out_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign t_out         = t_out_q;
  assign done          = done_q;
  assign err           = err_q;
  assign pulses_left   = left_q;
  assign busy          = (state_q != IDLE);
  assign cmd.cmd_ready = (state_q == IDLE);
endmodule

// File: tb/tb_tff_toggle_sequencer.sv
// Directed bench for tff_toggle_sequencer with a cycle-trace scoreboard and a
// behavioural T flip-flop bank on t_out.
module tb_tff_toggle_sequencer;
  localparam int NCH = 3;
  localparam int CW  = 8;
  localparam int GW  = 8;
  localparam int CHW = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           abort = 1'b0;
  logic [NCH-1:0] t_out;
  logic           busy, done, err;
  logic [CW-1:0]  pulses_left;
  logic [NCH-1:0] q_bank;
  logic [NCH-1:0] exp_q = '0;
  int             errors = 0;
  int             checks = 0;
  int             exp_left = 0;

  typedef struct packed {
    logic [NCH-1:0] t;
    logic           done;
    logic           err;
    logic           busy;
    logic           ready;
  } exp_t;
  exp_t sb[$];

  tff_toggle_sequencer_if #(.NCH(NCH), .CW(CW), .GW(GW)) cif ();

  tff_toggle_sequencer #(.NCH(NCH), .CW(CW), .GW(GW)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd         (cif),
    .abort       (abort),
    .t_out       (t_out),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .pulses_left (pulses_left)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q_bank <= '0;
    else      q_bank <= q_bank ^ t_out;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected per-cycle trace from cycle 1 after the accept edge, plus the
  // first cycle back in IDLE.
  function automatic void build(input int ch, input int count, input int gap, input int abort_at);
    int   done_c;
    int   issued;
    bit   bad;
    exp_t e;
    bad = (ch >= NCH);
    if (count == 0 || bad) done_c = 1;
    else                   done_c = 2 + (count - 1) * (gap + 1);
    if (abort_at > 0 && abort_at + 1 < done_c) done_c = abort_at + 1;
    issued = 0;
    for (int c = 1; c <= done_c; c++) begin
      e.t = '0;
      if (!bad && count > 0 && c < done_c && ((c - 1) % (gap + 1)) == 0) begin
        e.t = NCH'(1) << ch;
        issued++;
      end
      e.done  = (c == done_c);
      e.err   = (c == done_c) && bad && (count != 0);
      e.busy  = 1'b1;
      e.ready = 1'b0;
      sb.push_back(e);
    end
    e = '0;
    e.ready = 1'b1;
    sb.push_back(e);
    exp_left = count - issued;
  endfunction

  task automatic start_cmd(input int ch, input int count, input int gap, input int abort_at);
    @(negedge clk);
    cif.cmd_ch    = CHW'(ch);
    cif.cmd_count = CW'(count);
    cif.cmd_gap   = GW'(gap);
    cif.cmd_valid = 1'b1;
    build(ch, count, gap, abort_at);
    @(posedge clk);
  endtask

  task automatic check_trace(input string tag, input int abort_at, input bit hold, input int max_n);
    int   c;
    exp_t e;
    c = 0;
    while (sb.size() > 0 && c < max_n) begin
      @(negedge clk);
      c++;
      if (c == 1 && !hold) cif.cmd_valid = 1'b0;
      e = sb.pop_front();
      chk({tag, ".t_out"}, 32'(t_out), 32'(e.t));
      chk({tag, ".done"},  32'(done),  32'(e.done));
      chk({tag, ".err"},   32'(err),   32'(e.err));
      chk({tag, ".busy"},  32'(busy),  32'(e.busy));
      chk({tag, ".ready"}, 32'(cif.cmd_ready), 32'(e.ready));
      exp_q = exp_q ^ e.t;
      abort = (c == abort_at);
    end
    abort = 1'b0;
  endtask

  task automatic check_end(input string tag);
    chk({tag, ".pulses_left"}, 32'(pulses_left), 32'(exp_left));
    chk({tag, ".bank"}, 32'(q_bank), 32'(exp_q));
  endtask

  initial begin
    cif.cmd_valid = 1'b0;
    cif.cmd_ch    = '0;
    cif.cmd_count = '0;
    cif.cmd_gap   = '0;
    #12;
    chk("rst.t_out", 32'(t_out), 32'(0));
    chk("rst.done",  32'(done), 32'(0));
    chk("rst.err",   32'(err), 32'(0));
    chk("rst.busy",  32'(busy), 32'(0));
    chk("rst.left",  32'(pulses_left), 32'(0));
    chk("rst.ready", 32'(cif.cmd_ready), 32'(1));
    @(negedge clk);
    rst = 1'b1;

    start_cmd(1, 3, 2, 0);   check_trace("c1g2", 0, 1'b0, 100);  check_end("c1g2");
    start_cmd(2, 4, 0, 0);   check_trace("b2b", 0, 1'b0, 100);   check_end("b2b");
    start_cmd(1, 0, 5, 0);   check_trace("zero", 0, 1'b0, 100);  check_end("zero");
    start_cmd(3, 5, 0, 0);   check_trace("badch", 0, 1'b0, 100); check_end("badch");
    start_cmd(0, 10, 3, 6);  check_trace("abort", 6, 1'b0, 100); check_end("abort");

    // Idle hold of status
    repeat (3) @(negedge clk);
    chk("hold.left", 32'(pulses_left), 32'(exp_left));

    // Command held valid while busy: second one accepted only after IDLE
    start_cmd(2, 2, 1, 0);
    #1;
    cif.cmd_ch    = CHW'(0);
    cif.cmd_count = CW'(3);
    cif.cmd_gap   = GW'(0);
    check_trace("heldA", 0, 1'b1, 100);
    build(0, 3, 0, 0);
    check_trace("heldB", 0, 1'b0, 100);
    check_end("heldB");

    start_cmd(1, 2, 255, 0); check_trace("gapmax", 0, 1'b0, 600); check_end("gapmax");
    start_cmd(0, 255, 0, 0); check_trace("cntmax", 0, 1'b0, 600); check_end("cntmax");

    // Asynchronous reset mid-GAP
    start_cmd(0, 10, 3, 0);
    check_trace("prerst", 0, 1'b0, 6);
    #2;
    rst = 1'b0;
    #1;
    chk("arst.t_out", 32'(t_out), 32'(0));
    chk("arst.busy",  32'(busy), 32'(0));
    chk("arst.left",  32'(pulses_left), 32'(0));
    chk("arst.ready", 32'(cif.cmd_ready), 32'(1));
    chk("arst.done",  32'(done), 32'(0));
    sb.delete();
    exp_q = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("arst.nodone", 32'(done), 32'(0));
      chk("arst.not",    32'(t_out), 32'(0));
    end
    rst = 1'b1;
    @(negedge clk);
    chk("post.busy", 32'(busy), 32'(0));
    start_cmd(2, 2, 1, 0);   check_trace("post", 0, 1'b0, 100);  check_end("post");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
